// File: rtl/interval_timer.sv
// Programmable down-counting interval timer: prescaler-driven tick, one-shot or
// periodic reload, registered expire pulse and sticky interrupt.
module interval_timer #(
    parameter int unsigned PRESCALE_LIMIT = 1000,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic             running,
    output logic [WIDTH-1:0] count,
    output logic             expire,
    output logic             irq
);

    localparam int unsigned PW = $clog2(PRESCALE_LIMIT);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE_LIMIT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             running_q, running_d;
    logic             expire_q, expire_d;
    logic             irq_q, irq_d;

    logic in_run;
    logic tick;
    logic period_ok;
    logic reload;
    logic advance;
    logic expiry;

    // Event decode; stop outranks start, and both outrank the tick.
    always_comb begin
        in_run    = (state_q == RUN);
        tick      = in_run && (presc_q == PRESC_MAX);
        period_ok = (period_q != '0);
        reload    = start && !stop && period_ok;
        advance   = tick && !stop && !start;
        expiry    = advance && (count_q == WIDTH'(1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = period_ok ? RUN : IDLE;
        end else if (expiry && !mode_q) begin
            state_d = IDLE;
        end
    end

    // Prescaler, down counter and config register next values
    always_comb begin
        presc_d  = presc_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;

        if (stop || start) begin
            presc_d = '0;
            if (reload) begin
                count_d = period_q;
            end
        end else if (in_run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (advance) begin
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else if (expiry) begin
                    count_d = mode_q ? period_q : '0;
                end
            end
        end

        // A start in the same cycle as cfg_we already consumed the old values above.
        if (cfg_we) begin
            period_d = cfg_period;
            mode_d   = cfg_mode;
        end
    end

    // Output logic
    always_comb begin
        running_d = (state_d == RUN);
        expire_d  = expiry;
        irq_d     = expiry || (irq_q && !irq_ack);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            period_q  <= WIDTH'(DEFAULT_PERIOD);
            mode_q    <= 1'b0;
            running_q <= 1'b0;
            expire_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            expire_q  <= expire_d;
            irq_q     <= irq_d;
        end
    end

    assign running = running_q;
    assign count   = count_q;
    assign expire  = expire_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: directed vectors, a cycles-to-expiry reference model
// checked every cycle, and hand-computed literal expectations.
module tb_interval_timer;

    localparam int unsigned L = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_we = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic         cfg_mode = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         irq_ack = 1'b0;
    logic         running;
    logic [W-1:0] count;
    logic         expire;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    interval_timer #(.PRESCALE_LIMIT(L), .WIDTH(W), .DEFAULT_PERIOD(0)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .start(start), .stop(stop), .irq_ack(irq_ack),
        .running(running), .count(count), .expire(expire), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the interval is tracked as clock cycles left until expiry;
    // the visible count is that figure rounded up to whole ticks.
    bit     m_run;
    longint m_left;
    longint m_hold;
    longint m_period;
    bit     m_mode;
    bit     m_exp;
    bit     m_irq;

    function automatic longint ticks_left(input longint cycles);
        return (cycles + L - 1) / L;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_left = 0; m_hold = 0; m_period = 0;
            m_mode = 0; m_exp = 0; m_irq = 0;
        end else begin
            m_exp = 0;
            if (stop) begin
                if (m_run) begin
                    m_hold = ticks_left(m_left);
                    m_run  = 0;
                end
            end else if (start) begin
                if (m_period != 0) begin
                    m_run  = 1;
                    m_left = m_period * L;
                end else if (m_run) begin
                    m_hold = ticks_left(m_left);
                    m_run  = 0;
                end
            end else if (m_run) begin
                m_left--;
                if (m_left == 0) begin
                    m_exp = 1;
                    if (m_mode) begin
                        m_left = m_period * L;
                    end else begin
                        m_run  = 0;
                        m_hold = 0;
                    end
                end
            end
            m_irq = m_exp || (m_irq && !irq_ack);
            if (cfg_we) begin
                m_period = longint'(cfg_period);
                m_mode   = cfg_mode;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_running", longint'(running), longint'(m_run));
            chk("model_count", longint'(count), m_run ? ticks_left(m_left) : m_hold);
            chk("model_expire", longint'(expire), longint'(m_exp));
            chk("model_irq", longint'(irq), longint'(m_irq));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_cfg(input int p, input bit m);
        cfg_we = 1'b1; cfg_period = W'(p); cfg_mode = m;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    initial begin
        wait_cyc(2);
        chk("rst_running", longint'(running), 0);
        chk("rst_count", longint'(count), 0);
        chk("rst_irq", longint'(irq), 0);
        chk("rst_expire", longint'(expire), 0);
        rst = 1'b0;
        wait_cyc(1);

        // One-shot, period 3: expiry on edge 12
        do_cfg(3, 1'b0);
        do_start();
        chk("os_count_e0", longint'(count), 3);
        chk("os_running_e0", longint'(running), 1);
        wait_cyc(4);
        chk("os_count_e4", longint'(count), 2);
        wait_cyc(4);
        chk("os_count_e8", longint'(count), 1);
        wait_cyc(3);
        chk("os_expire_e11", longint'(expire), 0);
        wait_cyc(1);
        chk("os_expire_e12", longint'(expire), 1);
        chk("os_irq_e12", longint'(irq), 1);
        chk("os_running_e12", longint'(running), 0);
        chk("os_count_e12", longint'(count), 0);
        wait_cyc(1);
        chk("os_expire_e13", longint'(expire), 0);
        chk("os_irq_sticky", longint'(irq), 1);
        do_ack();
        chk("os_irq_acked", longint'(irq), 0);

        // Periodic, period 2: expiries on edges 8, 16, 24; ack at edge 10
        do_cfg(2, 1'b1);
        do_start();
        wait_cyc(8);
        chk("per_expire_e8", longint'(expire), 1);
        chk("per_count_e8", longint'(count), 2);
        wait_cyc(1);
        do_ack();
        chk("per_irq_ack_e10", longint'(irq), 0);
        chk("per_running_e10", longint'(running), 1);
        wait_cyc(6);
        chk("per_expire_e16", longint'(expire), 1);
        chk("per_irq_e16", longint'(irq), 1);
        wait_cyc(8);
        chk("per_expire_e24", longint'(expire), 1);
        chk("per_running_e24", longint'(running), 1);
        do_stop();
        chk("per_stopped", longint'(running), 0);

        // Period rewritten to 5 mid-run at cycle 3: expiries at edges 8 and 28
        do_start();
        wait_cyc(2);
        do_cfg(5, 1'b1);
        chk("newp_count_e3", longint'(count), 2);
        wait_cyc(5);
        chk("newp_expire_e8", longint'(expire), 1);
        chk("newp_count_e8", longint'(count), 5);
        wait_cyc(19);
        chk("newp_expire_e27", longint'(expire), 0);
        wait_cyc(1);
        chk("newp_expire_e28", longint'(expire), 1);
        do_stop();
        do_ack();

        // One-shot period 2, stop on the expiry tick edge
        do_cfg(2, 1'b0);
        do_start();
        wait_cyc(7);
        do_stop();
        chk("stopx_expire", longint'(expire), 0);
        chk("stopx_irq", longint'(irq), 0);
        chk("stopx_running", longint'(running), 0);
        chk("stopx_count", longint'(count), 1);
        wait_cyc(1);
        chk("stopx_expire_late", longint'(expire), 0);

        // cfg_we with start: start loads the old period (2)
        cfg_we = 1'b1; cfg_period = W'(6); cfg_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        chk("cfgstart_count", longint'(count), 2);
        do_stop();

        // Periodic expiry together with irq_ack: irq stays set
        do_cfg(2, 1'b1);
        do_start();
        wait_cyc(15);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("ackx_expire_e16", longint'(expire), 1);
        chk("ackx_irq_e16", longint'(irq), 1);
        do_stop();
        do_cfg(0, 1'b0);
        do_start();
        chk("zero_start_running", longint'(running), 0);

        // Async reset mid-run, between edges
        do_cfg(3, 1'b1);
        do_start();
        wait_cyc(5);
        #1 rst = 1'b1;
        #1;
        chk("arst_running", longint'(running), 0);
        chk("arst_count", longint'(count), 0);
        chk("arst_irq", longint'(irq), 0);
        chk("arst_expire", longint'(expire), 0);
        #1 rst = 1'b0;
        wait_cyc(1);
        do_start();
        chk("arst_default_start", longint'(running), 0);
        wait_cyc(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
